wb_timer_bridge: RTL and testbench

- Wishbone B4 pipelined slave to req/rvalid device-port bridge, sitting directly upstream of the machine timer.
- Converts one Wishbone access at a time into a single-cycle req pulse.
- Waits for the device's rvalid, then returns ack or err with read data to the bus master.
- Never more than one outstanding transaction.

---
 rtl/wb_timer_bridge.sv | 154 +++++++++++++++
 tb/tb_wb_timer_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer_bridge.sv
// Wishbone B4 pipelined slave to req/rvalid device-port bridge for the machine timer.
// Optional WAIT-state timeout is compiled in with `define WB_BRIDGE_TIMEOUT_EN.
module wb_timer_bridge #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [AddressWidth-3:0]   wb_adr_i,
  input  logic [DataWidth/8-1:0]    wb_sel_i,
  input  logic [DataWidth-1:0]      wb_dat_i,
  output logic                      wb_stall_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic [DataWidth-1:0]      wb_dat_o,
  output logic                      dev_req_o,
  output logic [AddressWidth-1:0]   dev_addr_o,
  output logic                      dev_we_o,
  output logic [DataWidth/8-1:0]    dev_be_o,
  output logic [DataWidth-1:0]      dev_wdata_o,
  input  logic                      dev_rvalid_i,
  input  logic [DataWidth-1:0]      dev_rdata_i,
  input  logic                      dev_err_i
);

  localparam int unsigned BeWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    abort_q, abort_d;
  logic                    aborted;
  logic                    ack_d, err_d, req_d, we_d;
  logic [DataWidth-1:0]    rdata_d, wdata_d;
  logic [AddressWidth-1:0] addr_d;
  logic [BeWidth-1:0]      be_d;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
  logic [CntWidth-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TimeoutCycles);
`endif

  assign wb_stall_o = (state_q != IDLE);

  // A master that drops cyc now or earlier in this access gets no completion.
  assign aborted = abort_q | ~wb_cyc_i;

  // Next-state and next registered-output logic.
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    req_d   = 1'b0;
    rdata_d = wb_dat_o;
    addr_d  = dev_addr_o;
    we_d    = dev_we_o;
    be_d    = dev_be_o;
    wdata_d = dev_wdata_o;
`ifdef WB_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_d  = {wb_adr_i, 2'b00};
          we_d    = wb_we_i;
          be_d    = wb_sel_i;
          wdata_d = wb_dat_i;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ, WAIT: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (state_q == REQ) begin
          state_d = WAIT;
`ifdef WB_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
        if (dev_rvalid_i) begin
          if (!dev_we_o) rdata_d = dev_rdata_i;
          if (!aborted) begin
            err_d = dev_err_i;
            ack_d = ~dev_err_i;
          end
          state_d = IDLE;
          abort_d = 1'b0;
        end
`ifdef WB_BRIDGE_TIMEOUT_EN
        else if (state_q == WAIT) begin
          if (cnt_q == CntLast) begin
            err_d   = ~aborted;
            state_d = IDLE;
            abort_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      abort_q     <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= '0;
      dev_req_o   <= 1'b0;
      dev_addr_o  <= '0;
      dev_we_o    <= 1'b0;
      dev_be_o    <= '0;
      dev_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      abort_q     <= abort_d;
      wb_ack_o    <= ack_d;
      wb_err_o    <= err_d;
      wb_dat_o    <= rdata_d;
      dev_req_o   <= req_d;
      dev_addr_o  <= addr_d;
      dev_we_o    <= we_d;
      dev_be_o    <= be_d;
      dev_wdata_o <= wdata_d;
    end
  end

`ifdef WB_BRIDGE_TIMEOUT_EN
  // WAIT-state cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_wb_timer_bridge.sv
// Self-checking bench for wb_timer_bridge: a cycle-indexed schedule of transactions
// yields both stimulus and expected outputs; pinned literals anchor the directed accesses.
module tb_wb_timer_bridge;

  localparam int NC = 1500;
  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [29:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic        wb_stall_o, wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic        dev_req_o;
  logic [31:0] dev_addr_o;
  logic        dev_we_o;
  logic [3:0]  dev_be_o;
  logic [31:0] dev_wdata_o;
  logic        dev_rvalid_i;
  logic [31:0] dev_rdata_i;
  logic        dev_err_i;

  wb_timer_bridge #(.DataWidth(32), .AddressWidth(32), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_stall_o(wb_stall_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
    .dev_req_o(dev_req_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
    .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Per-cycle stimulus (cycle c = interval after clock edge c).
  logic        s_cyc[NC], s_stb[NC], s_we[NC], s_rv[NC], s_derr[NC];
  logic [29:0] s_adr[NC];
  logic [3:0]  s_sel[NC];
  logic [31:0] s_dat[NC], s_rdata[NC];
  // Per-cycle expectations.
  logic        e_stall[NC], e_req[NC], e_ack[NC], e_err[NC], e_rd[NC], e_we[NC];
  logic [31:0] e_dat[NC], e_addr[NC], e_wdata[NC];
  logic [3:0]  e_be[NC];

  int errors = 0;
  int checks = 0;
  int f = 0;      // first cycle the bridge is idle again
  int min_p = 0;  // earliest cycle the next master request may start

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Place one access: master presents at cycle p, device answers d cycles after req.
  task automatic add_tr(input int p, input logic we, input logic [29:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat, input int d,
                        input logic [31:0] rdata, input logic derr, input int koff);
    int a, resp, k;
    logic to, ab;
    a  = (p > f) ? p : f;
    to = 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
    if (d > TO) to = 1'b1;
`endif
    resp = to ? a + 2 + TO : a + 2 + d;
    ab   = (koff >= 0);
    k    = ab ? a + 1 + (koff % (resp - 1 - a)) : resp + 1;
    for (int c = p; c <= a; c++) begin
      s_cyc[c] = 1'b1; s_stb[c] = 1'b1; s_we[c] = we;
      s_adr[c] = adr;  s_sel[c] = sel;  s_dat[c] = dat;
    end
    for (int c = a + 1; c < k && c <= resp; c++) s_cyc[c] = 1'b1;
    for (int c = a + 1; c <= a + d; c++) s_rv[c] = 1'b0;
    s_rv[a + 1 + d] = 1'b1; s_rdata[a + 1 + d] = rdata; s_derr[a + 1 + d] = derr;
    e_req[a + 1] = 1'b1;
    for (int c = a + 1; c < resp; c++) e_stall[c] = 1'b1;
    if (!ab) begin
      if (to || derr) e_err[resp] = 1'b1;
      else            e_ack[resp] = 1'b1;
      e_rd[resp]  = !to && !derr && !we;
      e_dat[resp] = rdata;
    end
    for (int c = a + 1; c < NC; c++) begin
      e_addr[c] = 32'(adr) * 4; e_we[c] = we; e_be[c] = sel; e_wdata[c] = dat;
    end
    f     = resp;
    min_p = (ab || to) ? ((resp > a + 2 + d) ? resp : a + 2 + d) : a + 1;
  endtask

  task automatic compare_cycle(input int c);
    chk("stall", c, 32'(wb_stall_o), 32'(e_stall[c]));
    chk("req",   c, 32'(dev_req_o),  32'(e_req[c]));
    chk("ack",   c, 32'(wb_ack_o),   32'(e_ack[c]));
    chk("err",   c, 32'(wb_err_o),   32'(e_err[c]));
    chk("addr",  c, dev_addr_o,      e_addr[c]);
    chk("we",    c, 32'(dev_we_o),   32'(e_we[c]));
    chk("be",    c, 32'(dev_be_o),   32'(e_be[c]));
    chk("wdata", c, dev_wdata_o,     e_wdata[c]);
    if (e_rd[c]) chk("rdata", c, wb_dat_o, e_dat[c]);
    // Hand-computed anchors for the directed accesses at the start of the schedule.
    case (c)
      3:  begin chk("t0_req", c, 32'(dev_req_o), 32'h1); chk("t0_addr", c, dev_addr_o, 32'h8); end
      5:  begin chk("t0_ack", c, 32'(wb_ack_o), 32'h1); chk("t0_dat", c, wb_dat_o, 32'h0000_1234); end
      7:  begin
            chk("t1_be", c, 32'(dev_be_o), 32'h3);       chk("t1_we", c, 32'(dev_we_o), 32'h1);
            chk("t1_wdata", c, dev_wdata_o, 32'hAABBCCDD); chk("t1_addr", c, dev_addr_o, 32'hC);
          end
      9:  begin chk("t1_ack", c, 32'(wb_ack_o), 32'h1); chk("t1_err", c, 32'(wb_err_o), 32'h0); end
      13: begin chk("t2_err", c, 32'(wb_err_o), 32'h1); chk("t2_ack", c, 32'(wb_ack_o), 32'h0); end
      16: chk("t3_stall", c, 32'(wb_stall_o), 32'h1);
      17: begin chk("t3_ack", c, 32'(wb_ack_o), 32'h1); chk("t3_stall", c, 32'(wb_stall_o), 32'h0); end
      18: chk("t4_req", c, 32'(dev_req_o), 32'h1);
      20: chk("t4_ack", c, 32'(wb_ack_o), 32'h1);
      26: begin chk("t5_noack", c, 32'(wb_ack_o | wb_err_o), 32'h0); chk("t5_stall", c, 32'(wb_stall_o), 32'h0); end
      30: chk("t6_ack", c, 32'(wb_ack_o), 32'h1);
      default: ;
    endcase
  endtask

  initial begin
    int p, d, koff, a_est;
    logic got_ack;
    for (int c = 0; c < NC; c++) begin
      s_cyc[c] = 1'b0; s_stb[c] = 1'b0; s_we[c] = 1'($urandom);
      s_adr[c] = 30'($urandom); s_sel[c] = 4'($urandom); s_dat[c] = $urandom;
      s_rv[c] = ($urandom_range(0, 4) == 0); s_rdata[c] = $urandom; s_derr[c] = 1'($urandom);
      e_stall[c] = 1'b0; e_req[c] = 1'b0; e_ack[c] = 1'b0; e_err[c] = 1'b0; e_rd[c] = 1'b0;
      e_dat[c] = '0; e_addr[c] = '0; e_we[c] = 1'b0; e_be[c] = '0; e_wdata[c] = '0;
    end
    add_tr(2,  1'b0, 30'h2,  4'hF, 32'h0,        1,  32'h0000_1234, 1'b0, -1);
    add_tr(6,  1'b1, 30'h3,  4'h3, 32'hAABBCCDD, 1,  32'h0,         1'b0, -1);
    add_tr(10, 1'b0, 30'h10, 4'hF, 32'h0,        1,  32'h0,         1'b1, -1);
    add_tr(14, 1'b0, 30'h1,  4'hF, 32'h0,        1,  32'h1111_2222, 1'b0, -1);
    add_tr(15, 1'b0, 30'h2,  4'hF, 32'h0,        1,  32'h3333_4444, 1'b0, -1);
    add_tr(21, 1'b0, 30'h2,  4'hF, 32'h0,        3,  32'h5555_6666, 1'b0, 1);
    add_tr(27, 1'b0, 30'h1,  4'hF, 32'h0,        1,  32'h7777_8888, 1'b0, -1);
    add_tr(31, 1'b0, 30'h3,  4'hF, 32'h0,        20, 32'h9999_AAAA, 1'b0, -1);
    while (1) begin
      p = min_p + int'($urandom_range(0, 4));
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 24)) : int'($urandom_range(0, 3));
      a_est = (p > f) ? p : f;
      if (a_est + d + TO + 8 >= NC) break;
      koff = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 30)) : -1;
      add_tr(p, 1'($urandom), 30'($urandom_range(0, 63)), 4'($urandom), $urandom, d,
             $urandom, ($urandom_range(0, 3) == 0), koff);
    end
    for (int c = 0; c < NC; c++) if (!s_cyc[c]) s_stb[c] = ($urandom_range(0, 3) == 0);

    // Reset: requests and responses must be ignored, outputs at reset values.
    rst_ni = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 30'h5;
    wb_sel_i = 4'hF; wb_dat_i = 32'h1; dev_rvalid_i = 1'b1; dev_rdata_i = 32'hFFFF; dev_err_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rst_stall", i, 32'(wb_stall_o), 32'h0);
      chk("rst_req",   i, 32'(dev_req_o),  32'h0);
      chk("rst_ack",   i, 32'(wb_ack_o | wb_err_o), 32'h0);
      chk("rst_addr",  i, dev_addr_o | dev_wdata_o | wb_dat_o, 32'h0);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; dev_rvalid_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;

    for (int c = 0; c < NC; c++) begin
      @(posedge clk_i); #1;
      wb_cyc_i = s_cyc[c]; wb_stb_i = s_stb[c]; wb_we_i = s_we[c]; wb_adr_i = s_adr[c];
      wb_sel_i = s_sel[c]; wb_dat_i = s_dat[c];
      dev_rvalid_i = s_rv[c]; dev_rdata_i = s_rdata[c]; dev_err_i = s_derr[c];
      @(negedge clk_i);
      compare_cycle(c);
    end

    // Reset in WAIT: immediate idle, then a late rvalid is ignored.
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 30'h5; dev_rvalid_i = 1'b0;
    @(posedge clk_i); #1; wb_stb_i = 1'b0;
    chk("mr_req", 0, 32'(dev_req_o), 32'h1);
    @(posedge clk_i); #1;
    chk("mr_wait", 0, 32'(wb_stall_o), 32'h1);
    rst_ni = 1'b0; #1;
    chk("mr_stall", 0, 32'(wb_stall_o), 32'h0);
    chk("mr_addr",  0, dev_addr_o, 32'h0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1; dev_rvalid_i = 1'b1; dev_rdata_i = 32'hDEAD_BEEF; dev_err_i = 1'b0;
    @(posedge clk_i); #1; dev_rvalid_i = 1'b0;
    chk("late_ack",   0, 32'(wb_ack_o | wb_err_o), 32'h0);
    chk("late_stall", 0, 32'(wb_stall_o), 32'h0);

    // Recovery access with an immediate device response; bounded wait for ack.
    wb_stb_i = 1'b1; wb_adr_i = 30'h7;
    @(posedge clk_i); #1; wb_stb_i = 1'b0;
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1; dev_rvalid_i = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 10 && !got_ack; i++) begin
      if (wb_ack_o) got_ack = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    chk("rec_ack", 0, 32'(got_ack), 32'h1);
    chk("rec_dat", 0, wb_dat_o, 32'hCAFE_F00D);
    wb_cyc_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
